// File: rtl/html_char_stream.sv
// Memory-backed character source for element_parser: fetches one byte per
// next_char request from a 1-cycle-latency byte memory and flags end of stream.
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

module html_char_stream #(
   parameter int ADDR_WIDTH = 10,
   parameter int START_ADDR = 0,
   parameter int MAX_LEN    = 1023
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    next_char,
   input  logic [`CHAR_BITES-1:0]  mem_data,
   output logic                    mem_rd,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [`CHAR_BITES-1:0]  char,
   output logic                    char_valid,
   output logic                    has_finished,
   output logic [ADDR_WIDTH:0]     char_count
);

   // state | meaning
   // IDLE  | waiting for a rising request
   // FETCH | read strobe on the bus, memory samples it this edge
   // WAIT  | read data present on mem_data
   // HOLD  | char delivered, waiting for the request to drop
   // DONE  | end of stream, frozen until reset
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_WIDTH:0]   MAX_CNT   = (ADDR_WIDTH+1)'(MAX_LEN);
   localparam logic [ADDR_WIDTH-1:0] START_VAL = ADDR_WIDTH'(START_ADDR);

   logic [2:0] state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         mem_rd       <= 1'b0;
         mem_addr     <= START_VAL;
         char         <= '0;
         char_valid   <= 1'b0;
         has_finished <= 1'b0;
         char_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (next_char) begin
                  if (char_count >= MAX_CNT) begin
                     has_finished <= 1'b1;
                     state        <= S_DONE;
                  end else begin
                     mem_rd <= 1'b1;
                     state  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               mem_rd <= 1'b0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // A NUL terminates the document and is never delivered.
               if (mem_data == '0) begin
                  has_finished <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  char       <= mem_data;
                  char_valid <= 1'b1;
                  char_count <= char_count + (ADDR_WIDTH+1)'(1);
                  mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!next_char) begin
                  char_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            S_DONE: begin
               mem_rd <= 1'b0;
            end
            default: begin
               mem_rd <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_html_char_stream.sv
// Bench for html_char_stream: three parameterisations, each fed by a byte
// memory model; directed handshakes plus randomized documents vs a queue model.
module tb_html_char_stream;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   logic        nc   [3];
   logic        rd   [3];
   logic [9:0]  addr [3];
   logic [7:0]  ch   [3];
   logic        cv   [3];
   logic        hf   [3];
   logic [10:0] cnt  [3];
   logic [7:0]  q    [3];

   logic [7:0] mem0 [1024];
   logic [7:0] mem1 [1024];
   logic [7:0] mem2 [4];

   logic [1:0] addr2;
   logic [2:0] cnt2;
   assign addr[2] = {8'b0, addr2};
   assign cnt[2]  = {8'b0, cnt2};

   html_char_stream dut0 (
      .clock(clock), .reset(reset), .next_char(nc[0]), .mem_data(q[0]),
      .mem_rd(rd[0]), .mem_addr(addr[0]), .char(ch[0]), .char_valid(cv[0]),
      .has_finished(hf[0]), .char_count(cnt[0]));

   html_char_stream #(.MAX_LEN(3)) dut1 (
      .clock(clock), .reset(reset), .next_char(nc[1]), .mem_data(q[1]),
      .mem_rd(rd[1]), .mem_addr(addr[1]), .char(ch[1]), .char_valid(cv[1]),
      .has_finished(hf[1]), .char_count(cnt[1]));

   html_char_stream #(.ADDR_WIDTH(2), .START_ADDR(3), .MAX_LEN(4)) dut2 (
      .clock(clock), .reset(reset), .next_char(nc[2]), .mem_data(q[2]),
      .mem_rd(rd[2]), .mem_addr(addr2), .char(ch[2]), .char_valid(cv[2]),
      .has_finished(hf[2]), .char_count(cnt2));

   // Synchronous memories: data registered on the edge that samples mem_rd.
   always @(posedge clock) begin
      if (rd[0]) q[0] <= mem0[addr[0]];
      if (rd[1]) q[1] <= mem1[addr[1]];
      if (rd[2]) q[2] <= mem2[addr2];
   end

   int rdcnt [3] = '{0, 0, 0};
   int rd_overlap = 0;
   logic prev_rd [3] = '{1'b0, 1'b0, 1'b0};
   always @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (rd[i]) rdcnt[i] <= rdcnt[i] + 1;
         if (rd[i] && prev_rd[i]) rd_overlap <= rd_overlap + 1;
         prev_rd[i] <= rd[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) nc[i] = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // One request/release handshake; ok=1 when a char was delivered.
   task automatic req(input int s, input int extra, output logic ok, output logic [7:0] c);
      ok = 1'b0;
      c  = 8'h00;
      nc[s] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (cv[s]) begin
            ok = 1'b1;
            c  = ch[s];
            break;
         end
         if (hf[s]) break;
      end
      repeat (extra) @(negedge clock);
      nc[s] = 1'b0;
      @(negedge clock);
      @(negedge clock);
   endtask

   logic ok;
   logic [7:0] c;
   int r0, pulses, nul_pos;
   logic [7:0] expq [$];
   string doc = "p size=68";

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) nc[i] = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = 8'h00;
         mem1[i] = "a";
      end
      for (int i = 0; i < doc.len(); i++) mem0[i] = doc[i];
      mem2[0] = "w"; mem2[1] = "x"; mem2[2] = "y"; mem2[3] = "z";
      @(negedge clock);
      do_reset();

      chk("rst_char", 32'(ch[0]), 32'h0);
      chk("rst_valid", 32'(cv[0]), 32'h0);
      chk("rst_fin", 32'(hf[0]), 32'h0);
      chk("rst_rd", 32'(rd[0]), 32'h0);
      chk("rst_addr2", 32'(addr[2]), 32'd3);
      chk("rst_count", 32'(cnt[0]), 32'h0);

      // Latency of the first request.
      r0 = rdcnt[0];
      nc[0] = 1'b1;
      @(negedge clock);
      chk("lat_rd_hi", 32'(rd[0]), 32'h1);
      chk("lat_addr", 32'(addr[0]), 32'h0);
      @(negedge clock);
      chk("lat_rd_lo", 32'(rd[0]), 32'h0);
      @(negedge clock);
      @(negedge clock);
      chk("lat_char", 32'(ch[0]), 32'("p"));
      chk("lat_valid", 32'(cv[0]), 32'h1);
      repeat (10) @(negedge clock);
      chk("held_one_fetch", 32'(rdcnt[0] - r0), 32'd1);
      nc[0] = 1'b0;
      @(negedge clock);
      @(negedge clock);

      // Remainder of the document.
      for (int i = 1; i < doc.len(); i++) begin
         req(0, 0, ok, c);
         chk("doc_ok", 32'(ok), 32'h1);
         chk("doc_char", 32'(c), 32'(doc[i]));
      end
      chk("doc_count", 32'(cnt[0]), 32'd9);
      req(0, 0, ok, c);
      chk("nul_fin", 32'(hf[0]), 32'h1);
      chk("nul_not_valid", 32'(ok), 32'h0);
      chk("nul_char_held", 32'(ch[0]), 32'("8"));
      chk("nul_count", 32'(cnt[0]), 32'd9);
      r0 = rdcnt[0];
      req(0, 0, ok, c);
      chk("done_no_rd", 32'(rdcnt[0] - r0), 32'd0);
      chk("done_addr", 32'(addr[0]), 32'd9);

      // Reset during WAIT of the second fetch.
      do_reset();
      req(0, 0, ok, c);
      chk("rw_first", 32'(c), 32'("p"));
      nc[0] = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      nc[0] = 1'b0;
      chk("rw_char", 32'(ch[0]), 32'h0);
      chk("rw_valid", 32'(cv[0]), 32'h0);
      chk("rw_addr", 32'(addr[0]), 32'h0);
      chk("rw_count", 32'(cnt[0]), 32'h0);
      @(negedge clock);
      @(negedge clock);
      req(0, 0, ok, c);
      chk("rw_restart", 32'(c), 32'("p"));

      // Request dropped right after it rises.
      nc[0] = 1'b1;
      @(negedge clock);
      nc[0] = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (cv[0]) begin
            pulses++;
            c = ch[0];
         end
      end
      chk("drop_pulses", 32'(pulses), 32'd1);
      chk("drop_char", 32'(c), 32'(" "));
      chk("drop_count", 32'(cnt[0]), 32'd2);
      req(0, 0, ok, c);
      chk("drop_next", 32'(c), 32'("s"));

      // Randomized documents: reference is the byte list up to the first NUL.
      for (int round = 0; round < 4; round++) begin
         nul_pos = $urandom_range(0, 40);
         expq.delete();
         for (int i = 0; i < 1024; i++) mem0[i] = 8'($urandom_range(1, 255));
         mem0[nul_pos] = 8'h00;
         for (int i = 0; i < nul_pos; i++) expq.push_back(mem0[i]);
         do_reset();
         while (expq.size() > 0) begin
            r0 = rdcnt[0];
            req(0, $urandom_range(0, 3), ok, c);
            chk("rnd_ok", 32'(ok), 32'h1);
            chk("rnd_char", 32'(c), 32'(expq.pop_front()));
            chk("rnd_one_rd", 32'(rdcnt[0] - r0), 32'd1);
         end
         req(0, 0, ok, c);
         chk("rnd_fin", 32'(hf[0]), 32'h1);
         chk("rnd_count", 32'(cnt[0]), 32'(nul_pos));
      end

      // MAX_LEN limit, no memory read on the terminating request.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req(1, 0, ok, c);
         chk("max_char", 32'(c), 32'("a"));
      end
      r0 = rdcnt[1];
      req(1, 0, ok, c);
      chk("max_fin", 32'(hf[1]), 32'h1);
      chk("max_no_rd", 32'(rdcnt[1] - r0), 32'd0);
      chk("max_count", 32'(cnt[1]), 32'd3);

      // Address wrap with a 2-bit memory starting at 3.
      for (int i = 0; i < 4; i++) begin
         req(2, 0, ok, c);
         chk("wrap_char", 32'(c), 32'(mem2[(3 + i) % 4]));
      end
      req(2, 0, ok, c);
      chk("wrap_fin", 32'(hf[2]), 32'h1);
      chk("wrap_addr", 32'(addr[2]), 32'd3);

      chk("rd_never_back_to_back", 32'(rd_overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
